// File: rtl/parallel_arbiter.sv
// parallel_arbiter: round-robin owner of a single serial-to-parallel shift lane.
// One requester at a time is granted the lane. Its strobed bits are collected
// MSB first into a p_width word, which is then presented with the source index.
// Optional build macro: PARALLEL_ARBITER_TIMEOUT_EN. When it is defined, a
// granted port that stops strobing is dropped after p_timeout idle cycles.
module parallel_arbiter #(
  parameter int p_width   = 8,
  parameter int p_ports   = 4,
  parameter int p_timeout = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [p_ports-1:0]         i_req,
  output logic [p_ports-1:0]         o_gnt,
  input  logic [p_ports-1:0]         i_val,
  input  logic [p_ports-1:0]         i_stp,
  output logic [p_width-1:0]         o_val,
  output logic [$clog2(p_ports)-1:0] o_src,
  output logic                       o_stp,
  output logic                       o_abt,
  output logic                       o_busy
);

  localparam int IW = $clog2(p_ports);
  localparam int CW = $clog2(p_width);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t               state_q, state_d;
  logic [p_ports-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [p_width-1:0]   shift_q, shift_d;
  logic [p_width-1:0]   val_q, val_d;
  logic [IW-1:0]        src_q, src_d;
  logic                 stp_q, stp_d;
  logic                 abt_q, abt_d;
  logic                 busy_q, busy_d;

  logic [IW-1:0]        pick_idx;
  logic                 pick_vld;
  logic                 g_req, g_stp, g_val;
  logic                 timeout_hit;

  // Index that is 'off' positions above 'base', wrapping modulo p_ports.
  function automatic logic [IW-1:0] wrap_idx(input int base, input int off);
    int k;
    k = base + off;
    if (k >= p_ports) k = k - p_ports;
    return IW'(k);
  endfunction

  // The pointer always holds the granted port while BUSY, so it selects the lane.
  assign g_req = i_req[ptr_q];
  assign g_stp = i_stp[ptr_q];
  assign g_val = i_val[ptr_q];

`ifdef PARALLEL_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(p_timeout + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;

  // Idle-bit counter: cleared on grant and on every accepted strobe.
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == ST_IDLE) begin
      tcnt_d = '0;
    end else if (g_stp) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  // Idle-bit counter register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) tcnt_q <= '0;
    else        tcnt_q <= tcnt_d;
  end

  // The cycle that would bring the count to p_timeout ends the transfer.
  assign timeout_hit = (state_q == ST_BUSY) && !g_stp &&
                       (tcnt_q == TW'(p_timeout - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Round-robin search upward from pointer+1; the nearest requester wins.
  always_comb begin
    pick_idx = ptr_q;
    pick_vld = 1'b0;
    for (int i = p_ports; i >= 1; i--) begin
      if (i_req[wrap_idx(int'(ptr_q), i)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_idx(int'(ptr_q), i);
      end
    end
  end

  // Next-state logic: grant in IDLE, shift/complete/abort in BUSY.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    val_d   = val_q;
    src_d   = src_q;
    stp_d   = 1'b0;
    abt_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d   = {{(p_ports-1){1'b0}}, 1'b1} << pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = '0;
          shift_d = '0;
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!g_req || timeout_hit) begin
          // Partial word is dropped; a strobe in this cycle is ignored.
          gnt_d   = '0;
          busy_d  = 1'b0;
          abt_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (g_stp) begin
          shift_d = {shift_q[p_width-2:0], g_val};
          if (cnt_q == CW'(p_width - 1)) begin
            val_d   = {shift_q[p_width-2:0], g_val};
            src_d   = ptr_q;
            stp_d   = 1'b1;
            gnt_d   = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset parks the pointer so port 0 wins first.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= IW'(p_ports - 1);
      cnt_q   <= '0;
      shift_q <= '0;
      val_q   <= '0;
      src_q   <= '0;
      stp_q   <= 1'b0;
      abt_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      val_q   <= val_d;
      src_q   <= src_d;
      stp_q   <= stp_d;
      abt_q   <= abt_d;
      busy_q  <= busy_d;
    end
  end

  assign o_gnt  = gnt_q;
  assign o_val  = val_q;
  assign o_src  = src_q;
  assign o_stp  = stp_q;
  assign o_abt  = abt_q;
  assign o_busy = busy_q;

endmodule

// File: doc/parallel_arbiter.md
# parallel_arbiter

Round-robin controller that shares one serial-to-parallel shift lane among `p_ports` serial requesters. It grants the lane to one requester at a time and collects exactly `p_width` strobed bits, MSB first. It then presents the assembled word with its source index and releases the grant. It sits between multiple serial front-ends and the single parallel word consumer in the encode path.

## Interface
- `p_width`, 8, word width in bits; ≥2
- `p_ports`, 4, number of requesters; ≥2
- `p_timeout`, 16, idle-bit timeout in cycles; ≥1; used only with the macro
- `i_clk`  in  1  clock, rising edge
- `i_rst`  in  1  reset; asynchronous, active-low
- `i_req`  in  p_ports  per-port lane request, level
- `o_gnt`  out  p_ports  one-hot grant, registered
- `i_val`  in  p_ports  per-port serial data bit
- `i_stp`  in  p_ports  per-port bit strobe; bit accepted when strobe high and port granted
- `o_val`  out  p_width  last completed word
- `o_src`  out  $clog2(p_ports)  index of the port that produced `o_val`
- `o_stp`  out  1  one-cycle pulse when a new word is completed
- `o_abt`  out  1  one-cycle pulse when a granted transfer is abandoned
- `o_busy`  out  1  high while a grant is held

## Operation
- Reset values: `o_gnt`=0, `o_val`=0, `o_src`=0, `o_stp`=0, `o_abt`=0, `o_busy`=0, FSM=IDLE, bit count=0, shift register=0, RR pointer=`p_ports`-1. With the pointer at this value, port 0 has the highest priority after reset.
- **IDLE:**
  - If any `i_req` is high, choose the first requester searching upward from pointer+1, wrapping around.
  - Register that requester in `o_gnt` and set the pointer to it.
  - Clear the count and shift register, then go to BUSY.
- **BUSY:**
  - Sample only the granted port's `i_val`/`i_stp`. Strobes, data and requests from other ports are ignored.
  - On each accepted strobe: shift ← (shift<<1)|bit; count++.
  - When the accepted strobe is bit `p_width`-1:
    - `o_val` ← final word, `o_src` ← granted index, `o_stp` pulse.
    - `o_gnt`←0, `o_busy`←0, go to IDLE.
- **Abort:** if the granted port drops `i_req` in BUSY before the final bit:
  - Discard the partial word. `o_val`/`o_src` are unchanged.
  - Pulse `o_abt`, drop the grant, go to IDLE.
  - A strobe arriving in the same cycle as the dropped request is discarded.
- `o_val`/`o_src` hold until the next completed word; they are never cleared except by reset.
- Async reset mid-transfer drops the grant immediately and loses the partial word; no `o_abt`.

## Timing
- Request sampled in IDLE at edge N → `o_gnt` high after edge N; the first bit can be accepted at edge N+1.
- With back-to-back strobes, the final bit is accepted at edge N+`p_width`. `o_stp`/`o_val`/`o_src` are valid and `o_gnt` is low in the following cycle.
- IDLE lasts at least one cycle between grants. Minimum period is `p_width`+1 edges per word.
- Fairness: a port that just finished ranks last. With all ports requesting continuously, grants cycle 0,1,2,3,0…
- Abort: `o_abt` and the grant drop take effect on the edge that samples `i_req` low.
- `o_stp` and `o_abt` are mutually exclusive.

## Configuration
- Macro `PARALLEL_ARBITER_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on grant and on each accepted strobe, and increments on every BUSY cycle with no accepted strobe.
  - When it reaches `p_timeout`, the transfer aborts exactly like a dropped request: `o_abt` pulse, grant released, pointer advanced past the port.
  - A port that holds its request but stops strobing therefore cannot hold the lane for more than `p_timeout` consecutive idle cycles.
- **Undefined:** no timeout logic is built. The grant is held until the final bit or until the request drops.

## Test plan
- Reset, then `i_req`=0001 and 8 back-to-back strobes on port 0 with bits 1,0,1,1,0,0,1,0 → `o_gnt`=0001 for 8 cycles, then `o_stp` pulse, `o_val`=8'hB2, `o_src`=0.
- `i_req`=1111 held, each granted port sends 8'h5A → grant order 0,1,2,3,0. There are 9 cycles per word, each word produces `o_stp`, and `o_src` steps 0,1,2,3.
- Port 2 granted, 3 bits sent, then `i_req[2]` drops → one `o_abt` pulse, no `o_stp`, `o_val` keeps its previous value, and the next grant goes to port 3 if it is requesting.
- Port 1 granted; strobes on ports 0/3 during the grant, bits sent with gaps 1–3 cycles between strobes → the word contains only port 1 bits, and the result is correct despite the gaps.
- With `PARALLEL_ARBITER_TIMEOUT_EN`, `p_timeout`=16: port 0 granted, 2 bits, then no strobe → `o_abt` on the 16th idle cycle. Without the macro, the grant is held indefinitely.
- Assert `i_rst` low mid-word on port 1 → all outputs return to reset values without waiting for a clock edge. After release, `i_req`=0110 → port 1 is granted first.
